// File: rtl/ucode_sequencer.sv
// Per-thread micro-PC sequencer feeding the microcode ROM and issuing to decode.
// Optional perf counters (uc_steps, uc_replays) under `UCSEQ_PERFCNT_EN.
module ucode_sequencer #(
  parameter int NTHREAD = 64,
  parameter int NTIDMSB = 5
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic             slot_valid,
  input  logic [NTIDMSB:0] slot_tid,
  input  logic             uc_entry,
  input  logic [4:0]       uc_entry_upc,
  input  logic             uc_commit,
  input  logic             flush_valid,
  input  logic [NTIDMSB:0] flush_tid,
  output logic [4:0]       rom_addr,
  input  logic [34:0]      rom_data,
  output logic             uc_valid,
  output logic [NTIDMSB:0] uc_tid,
  output logic [31:0]      uc_inst,
  output logic             uc_cwp_rs1,
  output logic             uc_cwp_rd,
  output logic             uc_active,
  output logic             uc_err
`ifdef UCSEQ_PERFCNT_EN
  ,
  output logic [31:0]      uc_steps,
  output logic [15:0]      uc_replays
`endif
);

  logic [NTHREAD-1:0] active;
  logic [4:0]         upc [NTHREAD];

  logic               s1_valid;
  logic [NTIDMSB:0]   s1_tid;
  logic [4:0]         s1_upc;

  logic slot_act;
  logic slot_flush;
  logic s1_flush;
  logic entry_ok;
  logic entry_bad;
  logic step;
  logic uend;
  logic wrap_err;

  assign slot_act   = active[slot_tid];
  assign slot_flush = flush_valid && (flush_tid == slot_tid);
  assign s1_flush   = flush_valid && (flush_tid == s1_tid);

  // A flush on the slot thread frees it, so a trap entry can land at once
  assign entry_ok  = slot_valid && uc_entry && (!slot_act || slot_flush);
  assign entry_bad = slot_valid && uc_entry && slot_act && !slot_flush;
  assign step      = slot_valid && slot_act && !slot_flush;

  assign uend     = rom_data[34];
  assign wrap_err = uc_valid && uc_commit && !uend && (s1_upc == 5'd31);

  assign uc_valid   = s1_valid && !s1_flush;
  assign uc_tid     = s1_tid;
  assign uc_inst    = uc_valid ? rom_data[31:0] : '0;
  assign uc_cwp_rs1 = uc_valid && rom_data[33];
  assign uc_cwp_rd  = uc_valid && rom_data[32];
  assign uc_active  = slot_act;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      active   <= '0;
      for (int i = 0; i < NTHREAD; i++) upc[i] <= '0;
      s1_valid <= 1'b0;
      s1_tid   <= '0;
      s1_upc   <= '0;
      rom_addr <= '0;
      uc_err   <= 1'b0;
    end else begin
      if (uc_valid && uc_commit) begin
        if (uend) begin
          active[s1_tid] <= 1'b0;
          upc[s1_tid]    <= '0;
        end else begin
          upc[s1_tid] <= s1_upc + 5'd1;
        end
      end
      if (flush_valid) active[flush_tid] <= 1'b0;
      s1_valid <= 1'b0;
      if (entry_ok) begin
        active[slot_tid] <= 1'b1;
        upc[slot_tid]    <= uc_entry_upc;
        rom_addr         <= uc_entry_upc;
        s1_valid         <= 1'b1;
        s1_tid           <= slot_tid;
        s1_upc           <= uc_entry_upc;
      end else if (step) begin
        rom_addr <= upc[slot_tid];
        s1_valid <= 1'b1;
        s1_tid   <= slot_tid;
        s1_upc   <= upc[slot_tid];
      end
      if (wrap_err || entry_bad) uc_err <= 1'b1;
    end
  end

`ifdef UCSEQ_PERFCNT_EN
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      uc_steps   <= '0;
      uc_replays <= '0;
    end else if (uc_valid) begin
      if (uc_commit) uc_steps <= uc_steps + 32'd1;
      else if (uc_replays != 16'hFFFF) uc_replays <= uc_replays + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a per-cycle reference model.
// Perf counter checks are built only with UCSEQ_PERFCNT_EN.
module tb_ucode_sequencer;

  logic        gclk = 1'b0;
  logic        rst = 1'b1;
  logic        slot_valid = 1'b0;
  logic [5:0]  slot_tid = '0;
  logic        uc_entry = 1'b0;
  logic [4:0]  uc_entry_upc = '0;
  logic        uc_commit = 1'b0;
  logic        flush_valid = 1'b0;
  logic [5:0]  flush_tid = '0;
  logic [4:0]  rom_addr;
  logic [34:0] rom_data;
  logic        uc_valid;
  logic [5:0]  uc_tid;
  logic [31:0] uc_inst;
  logic        uc_cwp_rs1;
  logic        uc_cwp_rd;
  logic        uc_active;
  logic        uc_err;
`ifdef UCSEQ_PERFCNT_EN
  logic [31:0] uc_steps;
  logic [15:0] uc_replays;
`endif

  int checks = 0;
  int failures = 0;

  logic [34:0] rom_mem [32];

  always #5 gclk = ~gclk;

  assign rom_data = rom_mem[rom_addr];

  ucode_sequencer dut (
    .gclk(gclk), .rst(rst),
    .slot_valid(slot_valid), .slot_tid(slot_tid),
    .uc_entry(uc_entry), .uc_entry_upc(uc_entry_upc),
    .uc_commit(uc_commit),
    .flush_valid(flush_valid), .flush_tid(flush_tid),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .uc_valid(uc_valid), .uc_tid(uc_tid), .uc_inst(uc_inst),
    .uc_cwp_rs1(uc_cwp_rs1), .uc_cwp_rd(uc_cwp_rd),
    .uc_active(uc_active), .uc_err(uc_err)
`ifdef UCSEQ_PERFCNT_EN
    , .uc_steps(uc_steps), .uc_replays(uc_replays)
`endif
  );

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: thread table, the word in flight, counters
  bit      m_active [64];
  int      m_upc [64];
  bit      p_valid;
  int      p_tid;
  int      p_upc;
  int      m_rom_addr;
  bit      m_err;
  longint  m_steps;
  int      m_replays;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_active[i] = 0;
      m_upc[i] = 0;
    end
    p_valid = 0; p_tid = 0; p_upc = 0;
    m_rom_addr = 0; m_err = 0;
    m_steps = 0; m_replays = 0;
  endtask

  always @(negedge gclk) begin
    bit ev, a_now, fl_hit, ue;
    int u_now, st, ft;
    if (rst) begin
      model_reset();
      chk("rst_valid", uc_valid, 0);
      chk("rst_tid", uc_tid, 0);
      chk("rst_inst", uc_inst, 0);
      chk("rst_rs1", uc_cwp_rs1, 0);
      chk("rst_rd", uc_cwp_rd, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_err", uc_err, 0);
    end else begin
      st = int'(slot_tid);
      ft = int'(flush_tid);
      ev = p_valid && !(flush_valid && ft == p_tid);
      chk("m_valid", uc_valid, ev);
      if (ev) begin
        chk("m_tid", uc_tid, p_tid);
        chk("m_inst", uc_inst, rom_mem[p_upc][31:0]);
        chk("m_rs1", uc_cwp_rs1, rom_mem[p_upc][33]);
        chk("m_rd", uc_cwp_rd, rom_mem[p_upc][32]);
      end
      chk("m_addr", rom_addr, m_rom_addr);
      chk("m_active", uc_active, m_active[st]);
      chk("m_err", uc_err, m_err);
`ifdef UCSEQ_PERFCNT_EN
      chk("m_steps", uc_steps, m_steps);
      chk("m_replays", uc_replays, m_replays);
`endif
      a_now = m_active[st];
      u_now = m_upc[st];
      fl_hit = flush_valid && ft == st;
      if (ev) begin
        ue = rom_mem[p_upc][34];
        if (uc_commit) begin
          m_steps = (m_steps + 1) % (64'd1 << 32);
          if (ue) begin
            m_active[p_tid] = 0;
            m_upc[p_tid] = 0;
          end else begin
            if (p_upc == 31) m_err = 1;
            m_upc[p_tid] = (p_upc + 1) % 32;
          end
        end else if (m_replays < 65535) begin
          m_replays++;
        end
      end
      if (flush_valid) m_active[ft] = 0;
      if (slot_valid && uc_entry && (!a_now || fl_hit)) begin
        m_active[st] = 1;
        m_upc[st] = int'(uc_entry_upc);
        m_rom_addr = int'(uc_entry_upc);
        p_valid = 1; p_tid = st; p_upc = int'(uc_entry_upc);
      end else if (slot_valid && a_now && !fl_hit) begin
        if (uc_entry) m_err = 1;
        m_rom_addr = u_now;
        p_valid = 1; p_tid = st; p_upc = u_now;
      end else begin
        p_valid = 0;
      end
    end
  end

  task automatic setin(bit sv, int tid, bit ent, int eupc, bit com,
                       bit fv, int ftid);
    slot_valid = sv;
    slot_tid = 6'(tid);
    uc_entry = ent;
    uc_entry_upc = 5'(eupc);
    uc_commit = com;
    flush_valid = fv;
    flush_tid = 6'(ftid);
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic step(bit sv, int tid, bit ent, int eupc, bit com,
                      bit fv, int ftid);
    setin(sv, tid, ent, eupc, com, fv, ftid);
    tick();
  endtask

  initial begin
    logic [4:0] a;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      rom_mem[i] = {(i == 2 || i == 8 || i == 10 || i == 21),
                    a[0], a[1], 32'h1000_0000 + 32'(i) * 32'h111};
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Two-word expansion for tid 5
    step(1, 5, 1, 7, 1, 0, 0);
    chk("std_addr7", rom_addr, 7);
    chk("std_valid0", uc_valid, 1);
    chk("std_tid0", uc_tid, 5);
    chk("std_inst7", uc_inst, 32'h1000_0777);
    step(1, 60, 0, 0, 1, 0, 0);
    step(1, 5, 0, 0, 1, 0, 0);
    chk("std_addr8", rom_addr, 8);
    chk("std_tid1", uc_tid, 5);
    step(0, 0, 0, 0, 1, 0, 0);
    setin(1, 5, 0, 0, 1, 0, 0);
    #1 chk("std_done", uc_active, 0);
    tick();

    // Replay on tid 2
    step(1, 2, 1, 9, 1, 0, 0);
    chk("rep_addr9", rom_addr, 9);
    step(1, 60, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 1, 0, 0);
    chk("rep_again9", rom_addr, 9);
    chk("rep_valid", uc_valid, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 2, 0, 0, 1, 0, 0);
    chk("rep_addr10", rom_addr, 10);
    step(0, 0, 0, 0, 1, 0, 0);

    // Flush and trap entry together on tid 7
    step(1, 7, 1, 13, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 7, 0, 0, 1, 0, 0);
    chk("trap_addr14", rom_addr, 14);
    setin(1, 7, 1, 0, 1, 1, 7);
    #1 chk("trap_squash", uc_valid, 0);
    tick();
    chk("trap_addr0", rom_addr, 0);
    chk("trap_err", uc_err, 0);
    setin(0, 0, 0, 0, 1, 0, 0);
    #1 chk("trap_valid", uc_valid, 1);
    chk("trap_tid", uc_tid, 7);
    chk("trap_inst", uc_inst, 32'h1000_0000);
    tick();
    setin(1, 7, 0, 0, 1, 0, 0);
    #1 chk("trap_active", uc_active, 1);
    tick();
    step(0, 0, 0, 0, 1, 0, 0);

    // Reset while tid 3 has a word in flight at upc 8
    step(1, 3, 1, 7, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    chk("rstm_addr8", rom_addr, 8);
    rst = 1'b1;
    #1 chk("rstm_valid", uc_valid, 0);
    chk("rstm_addr", rom_addr, 0);
    chk("rstm_inst", uc_inst, 0);
    tick();
    rst = 1'b0;
    setin(1, 3, 0, 0, 1, 0, 0);
    #1 chk("rstm_active", uc_active, 0);
    tick();

    // upc wrap at 31
    step(1, 9, 1, 31, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("wrap_err", uc_err, 1);
    step(1, 9, 0, 0, 1, 0, 0);
    chk("wrap_addr0", rom_addr, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Entry on an already active thread
    step(1, 4, 1, 20, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("dup_err0", uc_err, 0);
    step(1, 4, 1, 0, 0, 0, 0);
    chk("dup_addr21", rom_addr, 21);
    chk("dup_err1", uc_err, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Interleaved traffic over four threads
    for (int i = 0; i < 40; i++) begin
      step(1, 20 + i % 4, (i % 5) == 0, (i * 3) % 32, (i % 3) != 0,
           (i % 7) == 0, 20 + (i + 1) % 4);
    end
    step(0, 0, 0, 0, 1, 0, 0);

`ifdef UCSEQ_PERFCNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    step(1, 11, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 11, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 11, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 11, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 11, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("perf_steps", uc_steps, 3);
    chk("perf_replays", uc_replays, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
